mask_bbox: RTL and testbench

Consumes the binary skin mask and its delayed syncs from the 5x5 median filter and computes, per frame, the bounding box and pixel count of set mask pixels. Also re-renders the mask as RGB video with the previous frame's bounding box drawn as a red outline, ready for the HDMI output stage. It is the next stage downstream of the median filter in the skin-colour segmentation pipeline.

---
 rtl/mask_bbox_pkg.sv | 36 +++
 rtl/mask_bbox_pixel_pos_counter.sv | 59 +++++
 rtl/mask_bbox.sv | 158 +++++++++++++++
 tb/tb_mask_bbox.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mask_bbox_pkg.sv
// Shared types and constants for the mask bounding-box stage and later tracking stages.
// Latency: n/a (package only).
// Backpressure: n/a.
package mask_bbox_pkg;

   localparam int COORD_W = 11;
   localparam int CNT_W   = 21;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [CNT_W-1:0]   cnt_t;
   typedef logic [23:0]        rgb_t;

   typedef struct packed {
      coord_t x_min;
      coord_t x_max;
      coord_t y_min;
      coord_t y_max;
   } bbox_t;

   localparam rgb_t RED   = 24'hFF0000;
   localparam rgb_t WHITE = 24'hFFFFFF;
   localparam rgb_t BLACK = 24'h000000;

   localparam coord_t COORD_MAX = 11'h7FF;
   localparam cnt_t   CNT_MAX   = 21'h1FFFFF;

   // Empty box: min at the top of the range, max at zero, so the first pixel sets both
   localparam bbox_t BBOX_INIT = '{x_min: COORD_MAX, x_max: 11'd0,
                                   y_min: COORD_MAX, y_max: 11'd0};

   // Saturating coordinate increment
   function automatic coord_t sat_inc(input coord_t v);
      return (v == COORD_MAX) ? v : coord_t'(v + 11'd1);
   endfunction

endpackage

// File: rtl/mask_bbox_pixel_pos_counter.sv
// Pixel position generator: x within the line, y within the frame, plus the vsync rising-edge strobe.
// Latency: x/y describe the pixel presented this cycle; vs_edge is combinational on the current vsync.
// Backpressure: none; ce low holds all state and suppresses vs_edge.
module pixel_pos_counter
   import mask_bbox_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   ce,
   input  logic   in_de,
   input  logic   in_vsync,
   output coord_t x,
   output coord_t y,
   output logic   vs_edge
);

   coord_t x_q, x_d;
   coord_t y_q, y_d;
   logic   de_prev_q, de_prev_d;
   logic   vs_prev_q, vs_prev_d;

   assign vs_edge = ce & in_vsync & ~vs_prev_q;
   assign x       = x_q;
   assign y       = y_q;

   // Next position: x runs along active video, y steps at each line end and restarts on vsync
   always_comb begin
      x_d       = x_q;
      y_d       = y_q;
      de_prev_d = de_prev_q;
      vs_prev_d = vs_prev_q;
      if (ce) begin
         de_prev_d = in_de;
         vs_prev_d = in_vsync;
         x_d       = in_de ? sat_inc(x_q) : '0;
         if (vs_edge) begin
            y_d = '0;
         end else if (!in_de && de_prev_q) begin
            y_d = sat_inc(y_q);
         end
      end
   end

   // Position and edge-detect registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q       <= '0;
         y_q       <= '0;
         de_prev_q <= 1'b0;
         vs_prev_q <= 1'b0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         de_prev_q <= de_prev_d;
         vs_prev_q <= vs_prev_d;
      end
   end

endmodule

// File: rtl/mask_bbox.sv
// Per-frame bounding box and set-pixel count of the skin mask, plus RGB re-render with last box in red.
// Latency: video/syncs 1 cycle; latched box and frame_done visible 1 cycle after the vsync rising edge.
// Backpressure: none; ce low freezes every register including frame_done.
module mask_bbox
   import mask_bbox_pkg::*;
#(
   parameter logic [9:0]  H_SIZE     = 10'd83,
   parameter logic [20:0] MIN_PIXELS = 21'd16
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic         mask,
   input  logic         in_de,
   input  logic         in_hsync,
   input  logic         in_vsync,
   output logic         out_de,
   output logic         out_hsync,
   output logic         out_vsync,
   output logic [7:0]   out_r,
   output logic [7:0]   out_g,
   output logic [7:0]   out_b,
   output logic [10:0]  bbox_x_min,
   output logic [10:0]  bbox_x_max,
   output logic [10:0]  bbox_y_min,
   output logic [10:0]  bbox_y_max,
   output logic [20:0]  pix_count,
   output logic         bbox_valid,
   output logic         frame_done
);

   localparam coord_t X_LIM = coord_t'(H_SIZE) - 11'd1;

   coord_t pos_x, pos_y, acc_x;
   logic   vs_edge, border;

   bbox_t  acc_q, acc_d;
   cnt_t   cnt_q, cnt_d;
   bbox_t  box_q, box_d;
   cnt_t   pcount_q, pcount_d;
   logic   valid_q, valid_d;
   logic   fdone_q, fdone_d;
   logic   de_o_q, de_o_d, hs_o_q, hs_o_d, vs_o_q, vs_o_d;
   rgb_t   rgb_q, rgb_d;

   pixel_pos_counter u_pos (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .in_de    (in_de),
      .in_vsync (in_vsync),
      .x        (pos_x),
      .y        (pos_y),
      .vs_edge  (vs_edge)
   );

   // Coordinates beyond the active line width never widen the box
   assign acc_x = (pos_x > X_LIM) ? X_LIM : pos_x;

   // Accumulate the running frame; on the vsync edge latch it (edge wins over a coincident pixel)
   always_comb begin
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      box_d    = box_q;
      pcount_d = pcount_q;
      valid_d  = valid_q;
      fdone_d  = fdone_q;
      if (ce) begin
         fdone_d = vs_edge;
         if (vs_edge) begin
            pcount_d = cnt_q;
            if (cnt_q >= MIN_PIXELS) begin
               box_d   = acc_q;
               valid_d = 1'b1;
            end else begin
               box_d   = '0;
               valid_d = 1'b0;
            end
            acc_d = BBOX_INIT;
            cnt_d = '0;
         end else if (in_de && mask) begin
            if (acc_x < acc_q.x_min) acc_d.x_min = acc_x;
            if (acc_x > acc_q.x_max) acc_d.x_max = acc_x;
            if (pos_y < acc_q.y_min) acc_d.y_min = pos_y;
            if (pos_y > acc_q.y_max) acc_d.y_max = pos_y;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 21'd1;
         end
      end
   end

   // Border test against the box latched at the start of this frame
   always_comb begin
      border = valid_q &&
               ((((pos_x == box_q.x_min) || (pos_x == box_q.x_max)) &&
                 (pos_y >= box_q.y_min) && (pos_y <= box_q.y_max)) ||
                (((pos_y == box_q.y_min) || (pos_y == box_q.y_max)) &&
                 (pos_x >= box_q.x_min) && (pos_x <= box_q.x_max)));
   end

   // Overlay mux and sync alignment for the single video pipeline stage
   always_comb begin
      de_o_d = de_o_q;
      hs_o_d = hs_o_q;
      vs_o_d = vs_o_q;
      rgb_d  = rgb_q;
      if (ce) begin
         de_o_d = in_de;
         hs_o_d = in_hsync;
         vs_o_d = in_vsync;
         if (!in_de)      rgb_d = BLACK;
         else if (border) rgb_d = RED;
         else if (mask)   rgb_d = WHITE;
         else             rgb_d = BLACK;
      end
   end

   // Accumulator, frame latch and video registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q    <= BBOX_INIT;
         cnt_q    <= '0;
         box_q    <= '0;
         pcount_q <= '0;
         valid_q  <= 1'b0;
         fdone_q  <= 1'b0;
         de_o_q   <= 1'b0;
         hs_o_q   <= 1'b0;
         vs_o_q   <= 1'b0;
         rgb_q    <= BLACK;
      end else begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         box_q    <= box_d;
         pcount_q <= pcount_d;
         valid_q  <= valid_d;
         fdone_q  <= fdone_d;
         de_o_q   <= de_o_d;
         hs_o_q   <= hs_o_d;
         vs_o_q   <= vs_o_d;
         rgb_q    <= rgb_d;
      end
   end

   assign out_de     = de_o_q;
   assign out_hsync  = hs_o_q;
   assign out_vsync  = vs_o_q;
   assign out_r      = rgb_q[23:16];
   assign out_g      = rgb_q[15:8];
   assign out_b      = rgb_q[7:0];
   assign bbox_x_min = box_q.x_min;
   assign bbox_x_max = box_q.x_max;
   assign bbox_y_min = box_q.y_min;
   assign bbox_y_max = box_q.y_max;
   assign pix_count  = pcount_q;
   assign bbox_valid = valid_q;
   assign frame_done = fdone_q;

endmodule

// File: tb/tb_mask_bbox.sv
// Self-checking bench for mask_bbox: directed frames plus random masks against a frame-level model.
// Latency: expects video 1 cycle behind inputs and the frame latch 1 cycle after the vsync edge.
// Backpressure: exercises ce stalls mid-line.
module tb_mask_bbox;

   logic        clk = 1'b0;
   logic        rst, ce, mask, in_de, in_hsync, in_vsync;
   logic        out_de, out_hsync, out_vsync;
   logic [7:0]  out_r, out_g, out_b;
   logic [10:0] bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
   logic [20:0] pix_count;
   logic        bbox_valid, frame_done;

   mask_bbox #(.H_SIZE(10'd83), .MIN_PIXELS(21'd16)) dut (
      .clk(clk), .rst(rst), .ce(ce), .mask(mask), .in_de(in_de),
      .in_hsync(in_hsync), .in_vsync(in_vsync),
      .out_de(out_de), .out_hsync(out_hsync), .out_vsync(out_vsync),
      .out_r(out_r), .out_g(out_g), .out_b(out_b),
      .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
      .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max),
      .pix_count(pix_count), .bbox_valid(bbox_valid), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Current frame image and the set pixels the DUT has been shown so far
   bit img [0:15][0:127];
   int qx[$];
   int qy[$];

   // Model of the latched outputs and of the registered video
   int          m_xmin, m_xmax, m_ymin, m_ymax, m_cnt;
   bit          m_valid, m_fd;
   logic [26:0] m_vid;
   int          red_seen;
   int          fd_cnt;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {out_de, out_hsync, out_vsync, out_r, out_g, out_b,
                bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
                pix_count, bbox_valid, frame_done}, 128'd0);
   endtask

   function automatic bit on_border(input int x, input int y);
      return m_valid &&
             ((((x == m_xmin) || (x == m_xmax)) && (y >= m_ymin) && (y <= m_ymax)) ||
              (((y == m_ymin) || (y == m_ymax)) && (x >= m_xmin) && (x <= m_xmax)));
   endfunction

   // Frame summary computed from the list of set pixels
   task automatic latch_model();
      m_cnt = qx.size();
      if (m_cnt >= 16) begin
         m_xmin = 2047; m_xmax = 0; m_ymin = 2047; m_ymax = 0;
         foreach (qx[i]) begin
            if (qx[i] < m_xmin) m_xmin = qx[i];
            if (qx[i] > m_xmax) m_xmax = qx[i];
            if (qy[i] < m_ymin) m_ymin = qy[i];
            if (qy[i] > m_ymax) m_ymax = qy[i];
         end
         m_valid = 1'b1;
      end else begin
         m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
         m_valid = 1'b0;
      end
      qx.delete();
      qy.delete();
   endtask

   task automatic model_reset();
      qx.delete(); qy.delete();
      m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0; m_cnt = 0;
      m_valid = 1'b0; m_fd = 1'b0; m_vid = '0;
   endtask

   // One clock: drive inputs, predict, then check every output #1 after the edge
   task automatic cyc(input bit c, input bit de, input bit hs, input bit vs, input bit m,
                      input int x, input int y, input bit edge_ev);
      logic [26:0] ev;
      bit          efd;
      ce = c; in_de = de; in_hsync = hs; in_vsync = vs; mask = m;
      if (c) begin
         ev  = {de, hs, vs, de ? (on_border(x, y) ? 24'hFF0000 : (m ? 24'hFFFFFF : 24'h000000))
                               : 24'h000000};
         efd = edge_ev;
         if (edge_ev) latch_model();
         else if (de && m) begin qx.push_back(x); qy.push_back(y); end
      end else begin
         ev  = m_vid;
         efd = m_fd;
      end
      m_vid = ev;
      m_fd  = efd;
      @(posedge clk); #1;
      chk("video", {out_de, out_hsync, out_vsync, out_r, out_g, out_b}, m_vid);
      chk("frame_done", frame_done, m_fd);
      chk("latch", {bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, pix_count, bbox_valid},
          {m_xmin[10:0], m_xmax[10:0], m_ymin[10:0], m_ymax[10:0], m_cnt[20:0], m_valid});
      if ({out_r, out_g, out_b} == 24'hFF0000) red_seen++;
      if (frame_done) fd_cnt++;
   endtask

   task automatic vsync_pulse();
      fd_cnt = 0;
      repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 0, 0, 0, 1);
      repeat (2) cyc(1, 0, 0, 1, 0, 0, 0, 0);
      repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("fd_once", fd_cnt, 1);
   endtask

   // Active lines of width w; optional 3-cycle ce stall just before pixel (sx, sy)
   task automatic draw_lines(input int w, input int h, input int sx, input int sy);
      for (int y = 0; y < h; y++) begin
         for (int b = 0; b < 3; b++) cyc(1, 0, (b == 1), 0, 1'($urandom), 0, 0, 0);
         for (int x = 0; x < w; x++) begin
            if (x == sx && y == sy)
               for (int s = 0; s < 3; s++) cyc(0, 1, 1'($urandom), 0, 1'($urandom), 0, 0, 0);
            cyc(1, 1, 0, 0, img[y][x], x, y, 0);
         end
      end
      repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic clear_img();
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 128; x++) img[y][x] = 1'b0;
   endtask

   task automatic rect(input int x0, input int x1, input int y0, input int y1);
      clear_img();
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++) img[y][x] = 1'b1;
   endtask

   task automatic rand_img(input int w, input int h, input int dens);
      clear_img();
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) img[y][x] = ($urandom_range(0, 99) < dens);
   endtask

   task automatic chk_box(input string tag, input int x0, input int x1, input int y0,
                          input int y1, input int cnt, input bit v);
      logic [10:0] ex0, ex1, ey0, ey1;
      logic [20:0] ec;
      ex0 = x0[10:0]; ex1 = x1[10:0]; ey0 = y0[10:0]; ey1 = y1[10:0]; ec = cnt[20:0];
      chk(tag, {bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, pix_count, bbox_valid},
          {ex0, ex1, ey0, ey1, ec, v});
   endtask

   initial begin
      rst = 1'b0; ce = 1'b1; mask = 1'b0; in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
      model_reset();
      red_seen = 0; fd_cnt = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset_state");
      rst = 1'b1;

      // First frame after reset: no box yet; 10x5 block latched at the next edge
      rect(20, 29, 3, 7);
      red_seen = 0;
      draw_lines(83, 9, -1, -1);
      chk("first_frame_no_red", red_seen, 0);
      vsync_pulse();
      chk_box("block_box", 20, 29, 3, 7, 50, 1'b1);

      // All-zero frame shows only the previous box outline
      clear_img();
      red_seen = 0;
      draw_lines(83, 9, -1, -1);
      chk("outline_red_pixels", red_seen, 26);
      vsync_pulse();
      chk_box("empty_frame", 0, 0, 0, 0, 0, 1'b0);

      // Eight isolated pixels stay below the minimum count
      clear_img();
      for (int i = 0; i < 8; i++) img[(i % 3) * 2 + 1][5 + i * 10] = 1'b1;
      draw_lines(83, 9, -1, -1);
      vsync_pulse();
      chk_box("sparse_frame", 0, 0, 0, 0, 8, 1'b0);

      // Block again with a ce stall inside it; no red since the previous box was invalid
      rect(20, 29, 3, 7);
      red_seen = 0;
      draw_lines(83, 9, 24, 5);
      chk("no_red_after_sparse", red_seen, 0);
      vsync_pulse();
      chk_box("stalled_block", 20, 29, 3, 7, 50, 1'b1);

      // Random masks with random stall positions
      for (int f = 0; f < 4; f++) begin
         rand_img(40, 10, (f == 0) ? 2 : $urandom_range(5, 40));
         draw_lines(40, 10, $urandom_range(0, 39), $urandom_range(0, 9));
         vsync_pulse();
      end

      // Full-width 83x2 frame
      rect(0, 82, 0, 1);
      draw_lines(83, 2, -1, -1);
      vsync_pulse();
      chk_box("full_frame", 0, 82, 0, 1, 166, 1'b1);

      // Reset mid-frame after 30 set pixels; the partial frame is discarded
      rect(0, 9, 0, 2);
      draw_lines(83, 4, -1, -1);
      rst = 1'b0;
      in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; mask = 1'b0; ce = 1'b1;
      #2;
      chk_zero("reset_async");
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset_hold");
      rst = 1'b1;
      model_reset();
      clear_img();
      img[0][3] = 1'b1; img[0][40] = 1'b1; img[1][7] = 1'b1; img[1][80] = 1'b1;
      draw_lines(83, 2, -1, -1);
      vsync_pulse();
      chk_box("after_reset", 0, 0, 0, 0, 4, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
